oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 25 ++
 rtl/dma_pacer.sv | 40 ++++
 rtl/oam_dma.sv | 101 ++++++++++
 tb/tb_oam_dma.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared PPU package: OAM DMA state encoding, transfer length, source mapping.
// Build option OAM_DMA_SRC_CLAMP_EN folds E0-FF sources onto the C0-DF echo range.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    REQ,
    DATA,
    WRITE,
    PACE
  } dma_state_t;

  localparam int OAM_DMA_BYTES = 160;
  localparam logic [7:0] OAM_DMA_LAST = 8'(OAM_DMA_BYTES - 1);

  function automatic logic [7:0] clamp_src(input logic [7:0] hi);
`ifdef OAM_DMA_SRC_CLAMP_EN
    return (hi >= 8'hE0) ? hi - 8'h20 : hi;
`else
    return hi;
`endif
  endfunction

endpackage

// File: rtl/dma_pacer.sv
// Start-delay and per-byte pacing counter for the OAM DMA.
// Clears to zero, counts up saturating at 15, compares against TICKS-1.
module dma_pacer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic end_o,
  output logic past_o
);

  localparam logic [3:0] LAST = 4'(TICKS - 1);

  logic [3:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign end_o  = (cnt_q == LAST);
  assign past_o = (cnt_q >= LAST);

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src_hi, 00..9F} into OAM.
// Build option OAM_DMA_SRC_CLAMP_EN enables echo-RAM source mirroring.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write,
  input  logic [7:0]  d_wr,
  output logic [7:0]  reg_d_rd,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic        bus_gnt,
  input  logic [7:0]  src_d_in,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d_wr,
  output logic        oam_write,
  output logic        active,
  output logic        done
);

  dma_state_t state_q, state_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;
  logic       tmr_clr, tmr_inc;
  logic       tmr_end, tmr_past;

  dma_pacer #(.TICKS(TICKS)) u_pacer (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .end_o  (tmr_end),
    .past_o (tmr_past)
  );

  // next-state and datapath updates; a register write restarts from anywhere
  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    unique case (state_q)
      IDLE:  state_d = IDLE;
      START: if (tmr_end) state_d = REQ;
      REQ:   if (bus_gnt) state_d = DATA;
      DATA: begin
        buf_d   = src_d_in;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == OAM_DMA_LAST) state_d = IDLE;
        else if (tmr_past)         state_d = REQ;
        else                       state_d = PACE;
      end
      PACE:  if (tmr_end) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (reg_write) begin
      src_hi_d = d_wr;
      idx_d    = '0;
      state_d  = START;
    end
  end

  // pacer clears on restart and on every entry to REQ
  always_comb begin
    tmr_clr = reg_write || (state_d == REQ && state_q != REQ);
    tmr_inc = (state_q != IDLE);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      src_hi_q <= '0;
      idx_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
    end
  end

  assign reg_d_rd  = src_hi_q;
  assign active    = (state_q != IDLE);
  assign src_rd    = (state_q == REQ);
  assign oam_write = (state_q == WRITE);
  assign src_addr  = src_rd ? {clamp_src(src_hi_q), idx_q} : '0;
  assign oam_addr  = oam_write ? idx_q : '0;
  assign oam_d_wr  = oam_write ? buf_q : '0;
  // a restart coinciding with the last write cancels the completion
  assign done      = oam_write && (idx_q == OAM_DMA_LAST) && !reg_write;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma (TICKS=4 main instance, TICKS=3 side instance).
// Expected data is a fixed function of the source address.
module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [7:0]  d_wr;
  logic        bus_gnt;
  logic [7:0]  src_d_in, src_d_in3;

  logic [7:0]  reg_d_rd, reg_d_rd3;
  logic [15:0] src_addr, src_addr3;
  logic        src_rd, src_rd3;
  logic [7:0]  oam_addr, oam_addr3;
  logic [7:0]  oam_d_wr, oam_d_wr3;
  logic        oam_write, oam_write3;
  logic        active, active3;
  logic        done, done3;

  int n_chk = 0;
  int n_err = 0;
  int now = 0;
  int wr_edge = 0;
  int act_n = 0;

  int          w_cyc[$];
  logic [7:0]  w_addr[$];
  logic [7:0]  w_dat[$];
  int          d_cyc[$];
  logic [15:0] r_addr[$];
  int          w3_cyc[$];
  logic [7:0]  w3_addr[$];
  logic [7:0]  w3_dat[$];
  int          d3_cyc[$];

  logic        cur_wr, cur_rd;
  logic [7:0]  cur_oa;
  logic [15:0] cur_sa;

  oam_dma #(.TICKS(4)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .d_wr(d_wr),
    .reg_d_rd(reg_d_rd), .src_addr(src_addr), .src_rd(src_rd),
    .bus_gnt(bus_gnt), .src_d_in(src_d_in), .oam_addr(oam_addr),
    .oam_d_wr(oam_d_wr), .oam_write(oam_write), .active(active),
    .done(done)
  );

  oam_dma #(.TICKS(3)) dut3 (
    .clk(clk), .rst(rst), .reg_write(reg_write), .d_wr(d_wr),
    .reg_d_rd(reg_d_rd3), .src_addr(src_addr3), .src_rd(src_rd3),
    .bus_gnt(bus_gnt), .src_d_in(src_d_in3), .oam_addr(oam_addr3),
    .oam_d_wr(oam_d_wr3), .oam_write(oam_write3), .active(active3),
    .done(done3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // source memory: data valid the cycle after a granted request
  always @(posedge clk) begin
    if (src_rd && bus_gnt) src_d_in <= mem(src_addr);
    if (src_rd3 && bus_gnt) src_d_in3 <= mem(src_addr3);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    now++;
    cur_wr = oam_write;
    cur_rd = src_rd;
    cur_oa = oam_addr;
    cur_sa = src_addr;
    if (oam_write) begin
      w_cyc.push_back(now - wr_edge);
      w_addr.push_back(oam_addr);
      w_dat.push_back(oam_d_wr);
    end
    if (done) d_cyc.push_back(now - wr_edge);
    if (active) act_n++;
    if (src_rd && bus_gnt) r_addr.push_back(src_addr);
    if (oam_write3) begin
      w3_cyc.push_back(now - wr_edge);
      w3_addr.push_back(oam_addr3);
      w3_dat.push_back(oam_d_wr3);
    end
    if (done3) d3_cyc.push_back(now - wr_edge);
  endtask

  task automatic clear_logs();
    w_cyc.delete(); w_addr.delete(); w_dat.delete();
    d_cyc.delete(); r_addr.delete();
    w3_cyc.delete(); w3_addr.delete(); w3_dat.delete();
    d3_cyc.delete();
    act_n = 0;
  endtask

  task automatic do_write(input logic [7:0] v);
    reg_write = 1'b1;
    d_wr = v;
    wr_edge = now + 1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((active || active3) && n < budget);
    if (active || active3) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_wr(input logic [7:0] a, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cur_wr && cur_oa == a) && n < budget);
    if (!(cur_wr && cur_oa == a)) check("wr_timeout", 0, 1);
  endtask

  function automatic int exp_cyc(input int mode, input int i);
    if (mode == 0 || i < 5) return 6 + 4 * i;
    if (i == 5) return 36;
    return 39 + 4 * (i - 6);
  endfunction

  task automatic verify(input string tag, input logic [7:0] hi, input int mode);
    int bc, ba, bd, last;
    bc = 0; ba = 0; bd = 0;
    last = exp_cyc(mode, 159);
    check({tag, "_nwr"}, w_cyc.size(), 160);
    for (int i = 0; i < w_cyc.size() && i < 160; i++) begin
      if (w_cyc[i] != exp_cyc(mode, i)) bc++;
      if (w_addr[i] != 8'(i)) ba++;
      if (w_dat[i] != mem({hi, 8'(i)})) bd++;
    end
    check({tag, "_cyc_bad"}, bc, 0);
    check({tag, "_addr_bad"}, ba, 0);
    check({tag, "_data_bad"}, bd, 0);
    check({tag, "_ndone"}, d_cyc.size(), 1);
    if (d_cyc.size() > 0) check({tag, "_done_cyc"}, d_cyc[0], last);
    check({tag, "_active"}, act_n, last + 1);
  endtask

  initial begin
    logic [7:0] hi_fe;
    int bad;
    rst = 1'b0;
    reg_write = 1'b0;
    d_wr = 8'h00;
    bus_gnt = 1'b1;
    tick();
    tick();
    check("rst_outs", {active, src_rd, oam_write, done}, 0);
    check("rst_regrd", reg_d_rd, 8'h00);
    rst = 1'b1;
    tick();

    // basic transfer
    clear_logs();
    do_write(8'hC1);
    check("t1_regrd", reg_d_rd, 8'hC1);
    wait_idle(2000);
    verify("t1", 8'hC1, 0);

    // grant stall on byte 5
    clear_logs();
    do_write(8'hC1);
    wait_wr(8'd4, 100);
    bus_gnt = 1'b0;
    bad = 0;
    for (int i = 0; i < 20 && !cur_rd; i++) tick();
    for (int i = 0; i < 10; i++) begin
      if (!(cur_rd && cur_sa == 16'hC105)) bad++;
      tick();
    end
    if (!(cur_rd && cur_sa == 16'hC105)) bad++;
    bus_gnt = 1'b1;
    check("t2_stall_hold", bad, 0);
    wait_idle(2000);
    verify("t2", 8'hC1, 1);

    // rewrite during byte 80
    clear_logs();
    do_write(8'hC1);
    wait_wr(8'd80, 1000);
    check("t3_old_nwr", w_cyc.size(), 81);
    check("t3_old_done", d_cyc.size(), 0);
    clear_logs();
    do_write(8'hD0);
    check("t3_regrd", reg_d_rd, 8'hD0);
    wait_idle(2000);
    verify("t3", 8'hD0, 0);

    // asynchronous reset at byte 40
    clear_logs();
    do_write(8'hC1);
    wait_wr(8'd40, 1000);
    #3;
    rst = 1'b0;
    #1;
    check("t4_outs", {active, src_rd, oam_write, done}, 0);
    check("t4_regrd", reg_d_rd, 8'h00);
    tick();
    rst = 1'b1;
    clear_logs();
    for (int i = 0; i < 700; i++) tick();
    check("t4_nwr", w_cyc.size(), 0);
    check("t4_active", act_n, 0);

    // source FE: mirrored or raw
`ifdef OAM_DMA_SRC_CLAMP_EN
    hi_fe = 8'hDE;
`else
    hi_fe = 8'hFE;
`endif
    clear_logs();
    do_write(8'hFE);
    wait_idle(2000);
    check("t5_nrd", r_addr.size(), 160);
    bad = 0;
    for (int i = 0; i < r_addr.size() && i < 160; i++)
      if (r_addr[i] != {hi_fe, 8'(i)}) bad++;
    check("t5_src_bad", bad, 0);
    check("t5_regrd", reg_d_rd, 8'hFE);
    verify("t5", hi_fe, 0);

    // TICKS=3 instance
    clear_logs();
    do_write(8'h42);
    wait_idle(2000);
    check("t6_nwr", w3_cyc.size(), 160);
    bad = 0;
    for (int i = 0; i < w3_cyc.size() && i < 160; i++) begin
      if (w3_cyc[i] != 5 + 3 * i) bad++;
      if (w3_addr[i] != 8'(i)) bad++;
      if (w3_dat[i] != mem({8'h42, 8'(i)})) bad++;
    end
    check("t6_bad", bad, 0);
    check("t6_ndone", d3_cyc.size(), 1);
    if (d3_cyc.size() > 0) check("t6_done_cyc", d3_cyc[0], 482);
    check("t6_regrd", reg_d_rd3, 8'h42);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
